// File: rtl/finn_axis_lane_alu.sv
// -----------------------------------------------------------------------------
// finn_axis_lane_alu
//
// Purpose:
//   AXI4-Stream lane-wise ALU. Each C_LANE_WIDTH-bit lane of the input beat is
//   combined with a per-packet constant (add, subtract, bypass or unsigned
//   max). Lanes whose tkeep bytes are not all set pass through untouched.
//   A single compute register stage feeds a C_FIFO_DEPTH-entry buffer. A
//   registered output head sits after that buffer. The opcode and constant
//   are captured on the first beat of every packet.
//
// Build option:
//   FINN_AXIS_LANE_ALU_SAT_EN - when defined, add saturates to all-ones and
//   subtract clamps to zero. Otherwise both wrap modulo 2^C_LANE_WIDTH.
//
// Ports:
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   s_axis_*                  input stream (tvalid/tready/tdata/tkeep/tlast)
//   m_axis_*                  output stream (tvalid/tready/tdata/tkeep/tlast)
//   ctrl_op                   00 add, 01 sub (lane - constant), 10 bypass, 11 max
//   ctrl_constant             operand applied to every lane
//   pkt_count                 number of tlast beats sent on m_axis (wraps)
// -----------------------------------------------------------------------------
module finn_axis_lane_alu #(
   parameter int C_DATA_WIDTH = 512,
   parameter int C_LANE_WIDTH = 32,
   parameter int C_FIFO_DEPTH = 4
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst_n,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   input  logic [C_DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [C_DATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic                        s_axis_tlast,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [C_DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [C_DATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic                        m_axis_tlast,
   input  logic [1:0]                  ctrl_op,
   input  logic [C_LANE_WIDTH-1:0]     ctrl_constant,
   output logic [31:0]                 pkt_count
);

   localparam int KEEP_W     = C_DATA_WIDTH / 8;
   localparam int LANES      = C_DATA_WIDTH / C_LANE_WIDTH;
   localparam int LANE_BYTES = C_LANE_WIDTH / 8;
   localparam int PTR_W      = $clog2(C_FIFO_DEPTH);
   localparam int CNT_W      = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(C_FIFO_DEPTH);

   typedef enum logic {
      IDLE,
      IN_PKT
   } state_t;

   state_t                    state_q;
   state_t                    state_d;
   logic [1:0]                op_q;
   logic [C_LANE_WIDTH-1:0]   const_q;
   logic [1:0]                op_sel;
   logic [C_LANE_WIDTH-1:0]   const_sel;

   logic                      ready_en;
   logic                      s_accept;

   logic [C_DATA_WIDTH-1:0]   alu_data;
   logic                      stage_valid;
   logic [C_DATA_WIDTH-1:0]   stage_data;
   logic [KEEP_W-1:0]         stage_keep;
   logic                      stage_last;

   logic [C_DATA_WIDTH-1:0]   mem_data [C_FIFO_DEPTH];
   logic [KEEP_W-1:0]         mem_keep [C_FIFO_DEPTH];
   logic                      mem_last [C_FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr;
   logic [PTR_W-1:0]          rd_ptr;
   logic [CNT_W-1:0]          fifo_count;
   logic [CNT_W:0]            occupancy;
   logic                      fifo_push;
   logic                      fifo_pop;

   // Per-lane operation; all operands unsigned.
   function automatic logic [C_LANE_WIDTH-1:0] lane_alu(
      input logic [1:0]              op,
      input logic [C_LANE_WIDTH-1:0] a,
      input logic [C_LANE_WIDTH-1:0] k
   );
      logic [C_LANE_WIDTH-1:0] res;
`ifdef FINN_AXIS_LANE_ALU_SAT_EN
      logic [C_LANE_WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, k};
`endif
      res = a;
      case (op)
         2'b00: begin
`ifdef FINN_AXIS_LANE_ALU_SAT_EN
            res = sum[C_LANE_WIDTH] ? '1 : sum[C_LANE_WIDTH-1:0];
`else
            res = a + k;
`endif
         end
         2'b01: begin
`ifdef FINN_AXIS_LANE_ALU_SAT_EN
            res = (a < k) ? '0 : (a - k);
`else
            res = a - k;
`endif
         end
         2'b10:   res = a;
         default: res = (a > k) ? a : k;
      endcase
      return res;
   endfunction

   // ready_en holds s_axis_tready low during reset and until the first edge
   // after release, independent of the buffer occupancy.
   assign occupancy     = {1'b0, fifo_count} + {{CNT_W{1'b0}}, stage_valid};
   assign s_axis_tready = ready_en && (occupancy < DEPTH_L);
   assign s_accept      = s_axis_tvalid && s_axis_tready;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   // Packet FSM state register plus the captured opcode/constant.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= IDLE;
         op_q    <= 2'b00;
         const_q <= '0;
      end else begin
         state_q <= state_d;
         if (s_accept && (state_q == IDLE)) begin
            op_q    <= ctrl_op;
            const_q <= ctrl_constant;
         end
      end
   end

   // The first beat of a packet uses the live control inputs. Later beats use
   // the values captured on that first beat.
   always_comb begin
      state_d   = state_q;
      op_sel    = op_q;
      const_sel = const_q;
      case (state_q)
         IDLE: begin
            op_sel    = ctrl_op;
            const_sel = ctrl_constant;
            if (s_accept && !s_axis_tlast) begin
               state_d = IN_PKT;
            end
         end
         IN_PKT: begin
            if (s_accept && s_axis_tlast) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Lanes with any cleared keep byte are forwarded unchanged.
   always_comb begin
      alu_data = s_axis_tdata;
      for (int i = 0; i < LANES; i++) begin
         if (&s_axis_tkeep[i*LANE_BYTES +: LANE_BYTES]) begin
            alu_data[i*C_LANE_WIDTH +: C_LANE_WIDTH] =
               lane_alu(op_sel, s_axis_tdata[i*C_LANE_WIDTH +: C_LANE_WIDTH], const_sel);
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         stage_valid <= 1'b0;
         stage_data  <= '0;
         stage_keep  <= '0;
         stage_last  <= 1'b0;
      end else begin
         stage_valid <= s_accept;
         if (s_accept) begin
            stage_data <= alu_data;
            stage_keep <= s_axis_tkeep;
            stage_last <= s_axis_tlast;
         end
      end
   end

   // The stage always drains into the buffer on the next edge. The ready
   // equation guarantees a free slot for it.
   assign fifo_push = stage_valid;
   assign fifo_pop  = (fifo_count != '0) && (!m_axis_tvalid || m_axis_tready);

   always_ff @(posedge ap_clk) begin
      if (fifo_push) begin
         mem_data[wr_ptr] <= stage_data;
         mem_keep[wr_ptr] <= stage_keep;
         mem_last[wr_ptr] <= stage_last;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Registered output head. It refills from the buffer when empty or when
   // consumed, and holds its contents while stalled.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
      end else if (fifo_pop) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= mem_data[rd_ptr];
         m_axis_tkeep  <= mem_keep[rd_ptr];
         m_axis_tlast  <= mem_last[rd_ptr];
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         pkt_count <= 32'd0;
      end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
         pkt_count <= pkt_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_finn_axis_lane_alu.sv
// -----------------------------------------------------------------------------
// tb_finn_axis_lane_alu
//
// Directed bench for finn_axis_lane_alu at default parameters. Stimulus pushes
// the hand-computed expected beat into a scoreboard queue. An independent
// monitor pops and compares every beat leaving m_axis. While the output is
// stalled, the monitor checks the held beat against the queue head.
// -----------------------------------------------------------------------------
module tb_finn_axis_lane_alu;

   localparam int DW    = 512;
   localparam int LW    = 32;
   localparam int KW    = DW / 8;
   localparam int LANES = DW / LW;
   localparam int DEPTH = 4;

`ifdef FINN_AXIS_LANE_ALU_SAT_EN
   localparam logic [LW-1:0] EXP_ADD_OVF = 32'hFFFF_FFFF;
   localparam logic [LW-1:0] EXP_SUB_UNF = 32'h0000_0000;
`else
   localparam logic [LW-1:0] EXP_ADD_OVF = 32'h0000_0000;
   localparam logic [LW-1:0] EXP_SUB_UNF = 32'hFFFF_FFFE;
`endif

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   logic            ap_clk;
   logic            ap_rst_n;
   logic            s_axis_tvalid;
   logic            s_axis_tready;
   logic [DW-1:0]   s_axis_tdata;
   logic [KW-1:0]   s_axis_tkeep;
   logic            s_axis_tlast;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic [DW-1:0]   m_axis_tdata;
   logic [KW-1:0]   m_axis_tkeep;
   logic            m_axis_tlast;
   logic [1:0]      ctrl_op;
   logic [LW-1:0]   ctrl_constant;
   logic [31:0]     pkt_count;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_fails  = 0;
   int    cyc      = 0;
   int    accept_count      = 0;
   int    first_accept_edge = -1;
   int    first_valid_edge  = -1;
   bit    lat_armed         = 0;

   finn_axis_lane_alu #(
      .C_DATA_WIDTH (DW),
      .C_LANE_WIDTH (LW),
      .C_FIFO_DEPTH (DEPTH)
   ) dut (
      .ap_clk        (ap_clk),
      .ap_rst_n      (ap_rst_n),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .ctrl_op       (ctrl_op),
      .ctrl_constant (ctrl_constant),
      .pkt_count     (pkt_count)
   );

   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   always @(posedge ap_clk) cyc <= cyc + 1;

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Lane i holds base + i*step.
   function automatic logic [DW-1:0] ramp(input logic [LW-1:0] base, input logic [LW-1:0] step);
      logic [DW-1:0] v;
      for (int i = 0; i < LANES; i++) begin
         v[i*LW +: LW] = base + LW'(i) * step;
      end
      return v;
   endfunction

   function automatic logic [DW-1:0] splat(input logic [LW-1:0] val);
      logic [DW-1:0] v;
      for (int i = 0; i < LANES; i++) begin
         v[i*LW +: LW] = val;
      end
      return v;
   endfunction

   // Drives one beat until accepted and records its expected output.
   task automatic apply_stimulus(input logic [DW-1:0] data, input logic [KW-1:0] keep, input logic last,
                                 input logic [1:0] op, input logic [LW-1:0] k, input logic [DW-1:0] exp_data);
      int    waited = 0;
      beat_t e;
      e.data = exp_data;
      e.keep = keep;
      e.last = last;
      exp_q.push_back(e);
      s_axis_tdata  = data;
      s_axis_tkeep  = keep;
      s_axis_tlast  = last;
      ctrl_op       = op;
      ctrl_constant = k;
      s_axis_tvalid = 1'b1;
      forever begin
         @(negedge ap_clk);
         if (s_axis_tready) break;
         waited++;
         if (waited > 500) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL accept_timeout: got s_axis_tready=0, expected 1 within 500 cycles");
            break;
         end
      end
      if (s_axis_tready) begin
         accept_count++;
         if (first_accept_edge < 0) first_accept_edge = cyc + 1;
      end
      @(posedge ap_clk);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic drain(input string name);
      int waited = 0;
      while (exp_q.size() != 0) begin
         @(negedge ap_clk);
         waited++;
         if (waited > 500) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL %s_drain: got %0d beats outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
            break;
         end
      end
      @(posedge ap_clk);
      #1;
   endtask

   initial begin : monitor
      beat_t e;
      forever begin
         @(negedge ap_clk);
         if (ap_rst_n && m_axis_tvalid) begin
            if (lat_armed && first_valid_edge < 0) first_valid_edge = cyc;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("[TB] FAIL unexpected_beat: got m_axis_tvalid=1 with data 0x%0h, expected no beat", m_axis_tdata);
            end else if (m_axis_tready) begin
               e = exp_q.pop_front();
               check_output("out_data", m_axis_tdata, e.data);
               check_output("out_keep", DW'(m_axis_tkeep), DW'(e.keep));
               check_output("out_last", DW'(m_axis_tlast), DW'(e.last));
            end else begin
               check_output("stall_hold_data", m_axis_tdata, exp_q[0].data);
               check_output("stall_hold_last", DW'(m_axis_tlast), DW'(exp_q[0].last));
            end
         end
      end
   end

   initial begin : stimulus
      logic [DW-1:0] d;
      logic [DW-1:0] x;
      logic [KW-1:0] all_keep;

      all_keep      = '1;
      ap_rst_n      = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;
      ctrl_op       = 2'b00;
      ctrl_constant = '0;

      // Reset state and release behaviour.
      #2;
      ap_rst_n = 1'b0;
      repeat (3) @(negedge ap_clk);
      check_output("rst_s_tready", DW'(s_axis_tready), DW'(0));
      check_output("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
      check_output("rst_pkt_count", DW'(pkt_count), DW'(0));
      check_output("rst_m_tdata", m_axis_tdata, '0);
      check_output("rst_m_tkeep", DW'(m_axis_tkeep), DW'(0));
      check_output("rst_m_tlast", DW'(m_axis_tlast), DW'(0));
      ap_rst_n = 1'b1;
      #1;
      check_output("tready_before_edge", DW'(s_axis_tready), DW'(0));
      @(posedge ap_clk);
      #1;
      check_output("tready_after_edge", DW'(s_axis_tready), DW'(1));

      // 4-beat packet, add 1, with first-output latency measurement.
      $display("[TB] test: 4-beat add packet");
      lat_armed = 1;
      first_accept_edge = -1;
      first_valid_edge  = -1;
      for (int b = 0; b < 4; b++) begin
         apply_stimulus(ramp(LW'(b*16), 1), all_keep, (b == 3), 2'b00, 32'd1, ramp(LW'(b*16 + 1), 1));
      end
      drain("add4");
      lat_armed = 0;
      check_output("first_out_latency", DW'(first_valid_edge - first_accept_edge), DW'(2));
      check_output("pkt_count_after_add4", DW'(pkt_count), DW'(1));

      // Add overflow at the lane boundary.
      $display("[TB] test: add overflow");
      apply_stimulus(splat(32'hFFFF_FFFF), all_keep, 1'b1, 2'b00, 32'd1, splat(EXP_ADD_OVF));
      drain("add_ovf");

      // Opcode and constant held across the packet despite mid-packet changes.
      $display("[TB] test: control held mid-packet");
      apply_stimulus(splat(32'd3), all_keep, 1'b0, 2'b01, 32'd5, splat(EXP_SUB_UNF));
      apply_stimulus(splat(32'd3), all_keep, 1'b0, 2'b10, 32'd9, splat(EXP_SUB_UNF));
      apply_stimulus(splat(32'd3), all_keep, 1'b1, 2'b10, 32'd9, splat(EXP_SUB_UNF));
      drain("sub_hold");
      check_output("pkt_count_after_sub", DW'(pkt_count), DW'(3));

      // Unsigned max: even lanes below the constant, odd lanes above it.
      $display("[TB] test: max");
      for (int i = 0; i < LANES; i++) begin
         d[i*LW +: LW] = (i % 2 == 0) ? 32'd50 : 32'd200;
         x[i*LW +: LW] = (i % 2 == 0) ? 32'd100 : 32'd200;
      end
      apply_stimulus(d, all_keep, 1'b1, 2'b11, 32'd100, x);
      drain("max");

      // Bypass leaves data untouched.
      $display("[TB] test: bypass");
      apply_stimulus(ramp(32'h0101_0101, 32'h0101_0101), all_keep, 1'b1, 2'b10, 32'h0000_DEAD,
                     ramp(32'h0101_0101, 32'h0101_0101));
      drain("bypass");

      // Partial keep on the top lane: that lane passes through, keep unchanged.
      $display("[TB] test: partial tkeep");
      x = ramp(32'h27, 32'h1000);
      x[15*LW +: LW] = 32'h0000_F020;
      apply_stimulus(ramp(32'h20, 32'h1000), {4'h0, {60{1'b1}}}, 1'b1, 2'b00, 32'd7, x);
      drain("tkeep");
      check_output("pkt_count_after_tkeep", DW'(pkt_count), DW'(6));

      // Output stalled for 20 cycles while a 10-beat packet is offered.
      $display("[TB] test: backpressure");
      m_axis_tready = 1'b0;
      accept_count  = 0;
      fork
         begin : bp_driver
            for (int b = 0; b < 10; b++) begin
               apply_stimulus(ramp(LW'(b * 32'h10000), 1), all_keep, (b == 9), 2'b00, 32'h100,
                              ramp(LW'(b * 32'h10000 + 32'h100), 1));
            end
         end
         begin : bp_observer
            repeat (20) @(negedge ap_clk);
            check_output("bp_accept_count", DW'(accept_count), DW'(DEPTH + 1));
            check_output("bp_s_tready_low", DW'(s_axis_tready), DW'(0));
            check_output("bp_m_tvalid_held", DW'(m_axis_tvalid), DW'(1));
            @(posedge ap_clk);
            #1;
            m_axis_tready = 1'b1;
         end
      join
      drain("backpressure");
      check_output("pkt_count_after_bp", DW'(pkt_count), DW'(7));

      // Reset mid-packet with beats buffered.
      $display("[TB] test: reset mid-packet");
      m_axis_tready = 1'b0;
      apply_stimulus(splat(32'd10), all_keep, 1'b0, 2'b00, 32'd1, splat(32'd11));
      apply_stimulus(splat(32'd10), all_keep, 1'b0, 2'b00, 32'd1, splat(32'd11));
      repeat (3) @(posedge ap_clk);
      #1;
      check_output("pre_rst_m_tvalid", DW'(m_axis_tvalid), DW'(1));
      #2;
      ap_rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_output("async_rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
      check_output("async_rst_pkt_count", DW'(pkt_count), DW'(0));
      check_output("async_rst_s_tready", DW'(s_axis_tready), DW'(0));
      check_output("async_rst_m_tdata", m_axis_tdata, '0);
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      #1;
      check_output("rerst_tready_before_edge", DW'(s_axis_tready), DW'(0));
      @(posedge ap_clk);
      #1;
      m_axis_tready = 1'b1;
      apply_stimulus(splat(32'd10), all_keep, 1'b1, 2'b01, 32'd1, splat(32'd9));
      drain("post_reset");
      check_output("pkt_count_after_reset", DW'(pkt_count), DW'(1));

      repeat (3) @(posedge ap_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
